servo_instr_sequencer: RTL and testbench

Controller that sits between the bit-serial instruction receiver and the servo PWM channels. It captures each completed 10-bit instruction and queues it in a 4-entry command FIFO. It then restarts the receiver for the next word with a timed reset pulse, and holds the last commanded position per servo channel. When the FIFO is full, it stalls the receiver by withholding the restart. The receiver then holds its acknowledge, which back-pressures the MBED.

---
 rtl/servo_instr_sequencer_if.sv | 45 ++++
 rtl/servo_instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_servo_instr_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/servo_instr_sequencer_if.sv
// servo_instr_sequencer_if
// Groups the receiver handshake, the command FIFO head port and the
// position/status outputs of the servo instruction sequencer.
//   instruction_ready / instruction : completed word from the bit-serial receiver
//   rx_reset                        : restart pulse back to the receiver
//   cmd_valid / cmd_ready           : head-of-FIFO handshake to the PWM side
//   cmd_channel / cmd_position      : head entry fields
//   pos_flat                        : last popped position per channel, ch c at [8c+7:8c]
//   fifo_count                      : entries currently queued (0..4)
// master = sequencer side, slave = receiver/PWM/testbench side.
interface servo_instr_sequencer_if;
   logic        instruction_ready;
   logic [9:0]  instruction;
   logic        rx_reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_channel;
   logic [7:0]  cmd_position;
   logic [31:0] pos_flat;
   logic [2:0]  fifo_count;

   modport master (
      input  instruction_ready,
      input  instruction,
      input  cmd_ready,
      output rx_reset,
      output cmd_valid,
      output cmd_channel,
      output cmd_position,
      output pos_flat,
      output fifo_count
   );

   modport slave (
      output instruction_ready,
      output instruction,
      output cmd_ready,
      input  rx_reset,
      input  cmd_valid,
      input  cmd_channel,
      input  cmd_position,
      input  pos_flat,
      input  fifo_count
   );
endinterface

// File: rtl/servo_instr_sequencer.sv
// servo_instr_sequencer
// Captures each completed 10-bit instruction from the serial receiver into a
// 4-entry FIFO, restarts the receiver with a RST_CYCLES-long rx_reset pulse,
// and keeps the last popped position for each of the four servo channels.
// A full FIFO stalls the receiver by withholding the restart pulse.
// Ports:
//   clk   : system clock, all state changes on posedge
//   reset : asynchronous, active-high
//   bus   : servo_instr_sequencer_if.master (handshake, FIFO head, status)
module servo_instr_sequencer #(
   parameter int         RST_CYCLES = 4,
   parameter logic [7:0] CENTER     = 8'd128
) (
   input logic                      clk,
   input logic                      reset,
   servo_instr_sequencer_if.master  bus
);

   localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RESTART,
      WAIT_LOW
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nextCnt;
   logic             r_rxReset;
   logic             w_nextRxReset;

   logic [9:0]       r_mem [4];
   logic [1:0]       r_wrPtr;
   logic [1:0]       r_rdPtr;
   logic [2:0]       r_count;
   logic [7:0]       r_pos [4];

   logic             w_valid;
   logic             w_pop;
   logic             w_canPush;
   logic             w_push;
   logic [9:0]       w_head;

   // Head of the FIFO is presented combinationally; a full FIFO still accepts
   // a push when the head leaves on the same edge.
   always_comb begin
      w_valid   = (r_count != 3'd0);
      w_head    = r_mem[r_rdPtr];
      w_pop     = w_valid && bus.cmd_ready;
      w_canPush = (r_count != 3'd4) || w_pop;
   end

   // State, restart counter and rx_reset register. Reset lands in RESTART so
   // the receiver is held in reset for RST_CYCLES cycles after reset releases.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= RESTART;
         r_cnt     <= CNT_LOAD;
         r_rxReset <= 1'b1;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_rxReset <= w_nextRxReset;
      end
   end

   // Next-state logic. WAIT_LOW waits out the receiver's one-cycle-late clear
   // of instruction_ready so the same word is never pushed twice. In IDLE a
   // full FIFO with no pop simply leaves the receiver waiting (stall).
   always_comb begin
      w_nextState   = r_state;
      w_nextCnt     = r_cnt;
      w_nextRxReset = r_rxReset;
      w_push        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.instruction_ready && w_canPush) begin
               w_push        = 1'b1;
               w_nextState   = RESTART;
               w_nextRxReset = 1'b1;
               w_nextCnt     = CNT_LOAD;
            end
         end
         RESTART: begin
            if (r_cnt == '0) begin
               w_nextRxReset = 1'b0;
               w_nextState   = WAIT_LOW;
            end else begin
               w_nextCnt = r_cnt - 1'b1;
            end
         end
         WAIT_LOW: begin
            if (!bus.instruction_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // FIFO storage has no reset; only entries covered by r_count are ever read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= bus.instruction;
      end
   end

   // Pointers wrap naturally at 2 bits; simultaneous push and pop leaves the
   // count unchanged while both pointers advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= 2'd0;
         r_rdPtr <= 2'd0;
         r_count <= 3'd0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 2'd1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Each pop commits the head's position to its channel's register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < 4; c++) begin
            r_pos[c] <= CENTER;
         end
      end else if (w_pop) begin
         r_pos[w_head[9:8]] <= w_head[7:0];
      end
   end

   assign bus.rx_reset     = r_rxReset;
   assign bus.cmd_valid    = w_valid;
   assign bus.cmd_channel  = w_head[9:8];
   assign bus.cmd_position = w_head[7:0];
   assign bus.fifo_count   = r_count;
   assign bus.pos_flat     = {r_pos[3], r_pos[2], r_pos[1], r_pos[0]};

endmodule

// File: tb/tb_servo_instr_sequencer.sv
// tb_servo_instr_sequencer
// Self-checking bench for servo_instr_sequencer (RST_CYCLES = 4, CENTER = 128).
// A cycle table covers reset release and a single word; hand-written
// sequences cover overflow stall, stale ready, pointer wrap and async reset.
module tb_servo_instr_sequencer;

   logic clk;
   logic reset;

   servo_instr_sequencer_if bus ();

   servo_instr_sequencer #(
      .RST_CYCLES (4),
      .CENTER     (8'd128)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10 ns clock, posedges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rdy;
      logic [9:0]  instr;
      logic        crdy;
      logic        expRx;
      logic        expValid;
      logic [1:0]  expCh;
      logic [7:0]  expPos;
      logic [2:0]  expCount;
      logic [31:0] expFlat;
   } vec_t;

   vec_t       vecs [11];
   int         nChecks = 0;
   int         nFails  = 0;
   logic [9:0] expQueue [$];
   logic [7:0] expPos [4];
   int         expCount = 0;

   function automatic logic [31:0] flatModel();
      return {expPos[3], expPos[2], expPos[1], expPos[0]};
   endfunction

   // Drive one cycle of inputs, then sample 1 ns after the active edge.
   task automatic applyStimulus(input logic rdy, input logic [9:0] instr, input logic crdy);
      bus.instruction_ready = rdy;
      bus.instruction       = instr;
      bus.cmd_ready         = crdy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Remainder of a restart after the push edge: ready clears one cycle late,
   // rx_reset falls after the 4th edge, WAIT_LOW exits on the 5th.
   task automatic finishRestart(input logic [9:0] w);
      applyStimulus(1'b1, w, 1'b0);
      repeat (2) applyStimulus(1'b0, 10'd0, 1'b0);
      checkOutput("restart_rx_high", 32'(bus.rx_reset), 32'd1);
      applyStimulus(1'b0, 10'd0, 1'b0);
      checkOutput("restart_rx_low", 32'(bus.rx_reset), 32'd0);
      applyStimulus(1'b0, 10'd0, 1'b0);
   endtask

   // Push one word from IDLE with no downstream pop.
   task automatic sendWord(input logic [9:0] w);
      applyStimulus(1'b1, w, 1'b0);
      expQueue.push_back(w);
      expCount++;
      checkOutput("push_count", 32'(bus.fifo_count), 32'(expCount));
      checkOutput("push_rx", 32'(bus.rx_reset), 32'd1);
      finishRestart(w);
   endtask

   // Check the head against the model, pop it, and check the position bank.
   task automatic popCheck();
      logic [9:0] w;
      w = expQueue.pop_front();
      checkOutput("head_valid", 32'(bus.cmd_valid), 32'd1);
      checkOutput("head_channel", 32'(bus.cmd_channel), 32'(w[9:8]));
      checkOutput("head_position", 32'(bus.cmd_position), 32'(w[7:0]));
      applyStimulus(1'b0, 10'd0, 1'b1);
      expPos[w[9:8]] = w[7:0];
      expCount--;
      checkOutput("pop_pos_flat", bus.pos_flat, flatModel());
      checkOutput("pop_count", 32'(bus.fifo_count), 32'(expCount));
   endtask

   initial begin
      logic [9:0] w;

      // Reset release and one word (ch 2, pos 0x50) with cmd_ready held high.
      vecs[0]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80808080};
      vecs[1]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80808080};
      vecs[2]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80808080};
      vecs[3]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80808080};
      vecs[4]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80808080};
      vecs[5]  = '{1'b1, 10'h250, 1'b1, 1'b1, 1'b1, 2'd2, 8'h50, 3'd1, 32'h80808080};
      vecs[6]  = '{1'b1, 10'h250, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80508080};
      vecs[7]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80508080};
      vecs[8]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80508080};
      vecs[9]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80508080};
      vecs[10] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 32'h80508080};

      reset                 = 1'b1;
      bus.instruction_ready = 1'b0;
      bus.instruction       = 10'd0;
      bus.cmd_ready         = 1'b0;
      #1;
      checkOutput("reset_rx", 32'(bus.rx_reset), 32'd1);
      checkOutput("reset_count", 32'(bus.fifo_count), 32'd0);
      checkOutput("reset_valid", 32'(bus.cmd_valid), 32'd0);
      checkOutput("reset_pos_flat", bus.pos_flat, 32'h80808080);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].rdy, vecs[i].instr, vecs[i].crdy);
         checkOutput($sformatf("vec%0d_rx", i), 32'(bus.rx_reset), 32'(vecs[i].expRx));
         checkOutput($sformatf("vec%0d_valid", i), 32'(bus.cmd_valid), 32'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d_count", i), 32'(bus.fifo_count), 32'(vecs[i].expCount));
         checkOutput($sformatf("vec%0d_pos_flat", i), bus.pos_flat, vecs[i].expFlat);
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d_channel", i), 32'(bus.cmd_channel), 32'(vecs[i].expCh));
            checkOutput($sformatf("vec%0d_position", i), 32'(bus.cmd_position), 32'(vecs[i].expPos));
         end
      end

      expPos[0] = 8'h80;
      expPos[1] = 8'h80;
      expPos[2] = 8'h50;
      expPos[3] = 8'h80;
      expCount  = 0;

      // Overflow: four words fill the FIFO, the fifth stalls in IDLE.
      sendWord({2'd0, 8'h11});
      sendWord({2'd1, 8'h22});
      sendWord({2'd3, 8'h33});
      sendWord({2'd2, 8'h44});
      w = {2'd1, 8'h55};
      repeat (3) begin
         applyStimulus(1'b1, w, 1'b0);
         checkOutput("stall_count", 32'(bus.fifo_count), 32'd4);
         checkOutput("stall_rx", 32'(bus.rx_reset), 32'd0);
      end
      checkOutput("stall_head_channel", 32'(bus.cmd_channel), 32'd0);
      checkOutput("stall_head_position", 32'(bus.cmd_position), 32'h11);
      applyStimulus(1'b1, w, 1'b1);
      void'(expQueue.pop_front());
      expPos[0] = 8'h11;
      expQueue.push_back(w);
      checkOutput("swap_count", 32'(bus.fifo_count), 32'd4);
      checkOutput("swap_rx", 32'(bus.rx_reset), 32'd1);
      checkOutput("swap_pos_flat", bus.pos_flat, 32'h80508011);
      finishRestart(w);
      repeat (4) popCheck();
      checkOutput("drain_valid", 32'(bus.cmd_valid), 32'd0);

      // Stale ready: held high through restart and two cycles beyond.
      w = {2'd3, 8'hA5};
      applyStimulus(1'b1, w, 1'b0);
      expQueue.push_back(w);
      expCount++;
      checkOutput("stale_push_count", 32'(bus.fifo_count), 32'd1);
      repeat (4) applyStimulus(1'b1, w, 1'b0);
      checkOutput("stale_rx_fell", 32'(bus.rx_reset), 32'd0);
      repeat (2) begin
         applyStimulus(1'b1, w, 1'b0);
         checkOutput("stale_count_held", 32'(bus.fifo_count), 32'd1);
         checkOutput("stale_rx_low", 32'(bus.rx_reset), 32'd0);
      end
      applyStimulus(1'b0, 10'd0, 1'b0);
      checkOutput("stale_count_after_low", 32'(bus.fifo_count), 32'd1);
      sendWord({2'd0, 8'h5A});
      popCheck();
      popCheck();

      // Wrap-around: ten words, one push then one pop each.
      for (int i = 0; i < 10; i++) begin
         sendWord({2'(i % 4), 8'(8'hC0 + i)});
         popCheck();
      end
      checkOutput("wrap_final_pos_flat", bus.pos_flat, 32'hC7C6C9C8);

      // Async reset mid-RESTART with three entries queued.
      sendWord({2'd1, 8'h01});
      sendWord({2'd2, 8'h02});
      applyStimulus(1'b1, {2'd3, 8'h03}, 1'b0);
      checkOutput("pre_reset_count", 32'(bus.fifo_count), 32'd3);
      applyStimulus(1'b1, {2'd3, 8'h03}, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_count", 32'(bus.fifo_count), 32'd0);
      checkOutput("async_valid", 32'(bus.cmd_valid), 32'd0);
      checkOutput("async_rx", 32'(bus.rx_reset), 32'd1);
      checkOutput("async_pos_flat", bus.pos_flat, 32'h80808080);
      expQueue.delete();
      expCount = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b0, 10'd0, 1'b0);
         checkOutput($sformatf("rerun_rx%0d", k), 32'(bus.rx_reset), (k < 4) ? 32'd1 : 32'd0);
      end
      checkOutput("rerun_count", 32'(bus.fifo_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
